// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-lite memory slave with wait states and two-cycle ERROR response
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LG    = $clog2(NB);
  localparam int AW    = $clog2(MEM_DEPTH) + LG;
  localparam int BYTES = MEM_DEPTH * NB;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  dp_valid;
  logic [AW-1:0]         addr_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic                  accept, bad, done;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  unused_ok;

  assign unused_ok = ^{hburst, htrans[0]};

  // Bus outputs, address-phase error check and next-state/counter logic
  always_comb begin
    hready  = state == IDLE || state == ERR2;
    hresp   = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
    accept  = hsel && htrans[1] && hready;
    bad     = haddr >= ADDR_WIDTH'(BYTES) || int'(hsize) > LG ||
              (int'(haddr[LG-1:0]) & ((1 << hsize) - 1)) != 0;
    state_n = accept ? (bad ? ERR1 : (WAIT_STATES > 0 ? WAIT : IDLE))
            : state == WAIT ? (cnt == 4'd0 ? IDLE : WAIT)
            : state == ERR1 ? ERR2 : IDLE;
    cnt_n   = (accept && !bad && WAIT_STATES > 0) ? 4'(WAIT_STATES - 1)
            : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
  end

  // State, wait counter and registered address phase; reset drops any pending transfer
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dp_valid <= 1'b0;
      addr_q   <= '0;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dp_valid <= accept ? !bad : dp_valid && !hready;
      if (accept) begin
        addr_q  <= haddr[AW-1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  // Byte enables for the completing write and full-width read data on read completion
  always_comb begin
    done   = dp_valid && hready;
    be     = '0;
    for (int i = 0; i < NB; i++)
      be[i] = done && write_q && i >= int'(addr_q[LG-1:0]) &&
              i < int'(addr_q[LG-1:0]) + (1 << size_q);
    hrdata = (done && !write_q) ? mem[addr_q[AW-1:LG]] : '0;
  end

  // Memory array has no reset so contents survive hresetn
  always_ff @(posedge hclk) begin
    for (int i = 0; i < NB; i++)
      if (be[i]) mem[addr_q[AW-1:LG]][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed vectors, corner sequences and random traffic against a byte-array bus model
module tb_ahb_slave_mem;
  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata;
  logic [2:0]  hready_v;
  logic [1:0]  hresp_v [3];
  logic [31:0] hrdata_v [3];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.WAIT_STATES(0)) u0 (.hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready_v[0]), .hresp(hresp_v[0]), .hrdata(hrdata_v[0]));
  ahb_slave_mem #(.WAIT_STATES(2)) u2 (.hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready_v[1]), .hresp(hresp_v[1]), .hrdata(hrdata_v[1]));
  ahb_slave_mem #(.WAIT_STATES(3)) u3 (.hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[2]), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready_v[2]), .hresp(hresp_v[2]), .hrdata(hrdata_v[2]));

  typedef struct {bit v; bit w; logic [31:0] a; logic [2:0] sz; logic [31:0] d; bit err;} xf_t;
  typedef struct {int k; bit w; logic [31:0] a; logic [2:0] sz; logic [31:0] d;
                  logic [31:0] rd; logic [1:0] resp; int waits;} vec_t;

  logic [7:0]  mm [3][1024];
  int          ws_of [3] = '{0, 2, 3};
  int          checks = 0, errors = 0, cur = 0, p = 0;
  xf_t         dp;
  logic        last_rdy;
  logic [1:0]  last_resp;
  logic [31:0] last_rd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: inst %0d got %h expected %h", nm, cur, act, exp);
    end
  endtask

  function automatic xf_t mk(bit w, logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    xf_t t;
    t.v = 1'b1; t.w = w; t.a = a; t.sz = sz; t.d = d;
    t.err = a >= 32'd1024 || sz > 3'd2 || (a & ((32'd1 << sz) - 32'd1)) != 32'd0;
    return t;
  endfunction

  function automatic logic [31:0] word_at(int k, logic [31:0] a);
    int b = int'(a) & ~3;
    return {mm[k][b+3], mm[k][b+2], mm[k][b+1], mm[k][b]};
  endfunction

  function automatic xf_t rand_xf();
    logic [2:0]  sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    logic [31:0] a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4096)) : 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
    return mk(1'($urandom_range(0, 1)), a, sz, $urandom);
  endfunction

  task automatic drive_junk(bit selected);
    hsel_v = selected ? 3'(1 << cur) : 3'b000;
    htrans = 2'($urandom); haddr = $urandom; hwrite = 1'($urandom);
    hsize  = 3'($urandom); hburst = 3'($urandom);
  endtask

  // One bus cycle: expected outputs come from the rules for the transfer now in its data phase
  task automatic step(input bit use_ap, input xf_t ap, output bit taken);
    bit er; logic [1:0] es; logic [31:0] ed;
    er = 1'b1; es = 2'b00; ed = 32'h0;
    if (dp.v && dp.err) begin
      er = (p == 1); es = 2'b01;
    end else if (dp.v) begin
      er = (p == ws_of[cur]);
      ed = (er && !dp.w) ? word_at(cur, dp.a) : 32'h0;
    end
    if (!er) drive_junk(1'b1);
    else if (use_ap) begin
      hsel_v = 3'(1 << cur); htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      haddr = ap.a; hwrite = ap.w; hsize = ap.sz; hburst = 3'($urandom);
    end else begin
      drive_junk(1'($urandom_range(0, 1)));
      if (hsel_v != 3'b000) htrans[1] = 1'b0;
    end
    hwdata = dp.v ? dp.d : $urandom;
    @(negedge hclk);
    last_rdy = hready_v[cur]; last_resp = hresp_v[cur]; last_rd = hrdata_v[cur];
    chk("hready", 32'(last_rdy), 32'(er));
    chk("hresp", 32'(last_resp), 32'(es));
    chk("hrdata", last_rd, ed);
    @(posedge hclk); #1;
    taken = er && use_ap;
    if (er) begin
      if (dp.v && !dp.err && dp.w)
        for (int b = 0; b < (1 << dp.sz); b++)
          mm[cur][int'(dp.a) + b] = dp.d[8*(int'(dp.a[1:0]) + b) +: 8];
      dp = use_ap ? ap : '{default: 0};
      p  = 0;
    end else p++;
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                      output logic [31:0] rd, output logic [1:0] resp, output int waits);
    bit tk; int n = 0;
    step(1'b1, mk(w, a, sz, d), tk);
    waits = 0;
    while (dp.v && n < 40) begin
      step(1'b0, dp, tk);
      waits += int'(!last_rdy);
      n++;
    end
    rd = last_rd; resp = last_resp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv [17];
    logic [31:0] rd; logic [1:0] rs; int wt; bit tk;
    tv = '{
      '{0, 1'b1, 32'h020, 3'd2, 32'h11223344, 32'h0,        2'b00, 0},
      '{0, 1'b1, 32'h023, 3'd0, 32'hAA000000, 32'h0,        2'b00, 0},
      '{0, 1'b0, 32'h020, 3'd2, 32'h0,        32'hAA223344, 2'b00, 0},
      '{0, 1'b1, 32'h022, 3'd1, 32'h55660000, 32'h0,        2'b00, 0},
      '{0, 1'b0, 32'h020, 3'd2, 32'h0,        32'h55663344, 2'b00, 0},
      '{0, 1'b1, 32'h400, 3'd2, 32'hCAFEF00D, 32'h0,        2'b01, 1},
      '{0, 1'b1, 32'h011, 3'd1, 32'hFFFFFFFF, 32'h0,        2'b01, 1},
      '{0, 1'b0, 32'h010, 3'd2, 32'h0,        32'hDEADBEEF, 2'b00, 0},
      '{0, 1'b0, 32'h020, 3'd2, 32'h0,        32'h55663344, 2'b00, 0},
      '{0, 1'b0, 32'h008, 3'd3, 32'h0,        32'h0,        2'b01, 1},
      '{1, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h0,        2'b00, 2},
      '{1, 1'b0, 32'h010, 3'd2, 32'h0,        32'hDEADBEEF, 2'b00, 2},
      '{1, 1'b1, 32'h401, 3'd2, 32'h0,        32'h0,        2'b01, 1},
      '{2, 1'b1, 32'h3FC, 3'd2, 32'h0BADC0DE, 32'h0,        2'b00, 3},
      '{2, 1'b0, 32'h3FC, 3'd2, 32'h0,        32'h0BADC0DE, 2'b00, 3},
      '{2, 1'b0, 32'h3FF, 3'd0, 32'h0,        32'h0BADC0DE, 2'b00, 3},
      '{2, 1'b0, 32'h400, 3'd0, 32'h0,        32'h0,        2'b01, 1}
    };
    dp = '{default: 0};
    hresetn = 1'b0;
    repeat (3) begin
      hsel_v = 3'($urandom); htrans = 2'($urandom); haddr = $urandom; hwrite = 1'($urandom);
      hsize = 3'($urandom); hburst = 3'($urandom); hwdata = $urandom;
      @(negedge hclk);
      for (int k = 0; k < 3; k++) begin
        cur = k;
        chk("rst_hready", 32'(hready_v[k]), 32'd1);
        chk("rst_hresp", 32'(hresp_v[k]), 32'd0);
        chk("rst_hrdata", hrdata_v[k], 32'd0);
      end
      @(posedge hclk); #1;
    end
    hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int w = 0; w < 256; w++) xfer(1'b1, 32'(w * 4), 3'd2, $urandom, rd, rs, wt);
    end
    cur = 0;
    step(1'b1, mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF), tk);
    step(1'b1, mk(1'b0, 32'h10, 3'd2, 32'h0), tk);
    chk("pipe_wr_done", 32'(last_rdy), 32'd1);
    step(1'b0, dp, tk);
    chk("pipe_rd_data", last_rd, 32'hDEADBEEF);
    chk("pipe_rd_resp", 32'(last_resp), 32'd0);
    for (int i = 0; i < 17; i++) begin
      cur = tv[i].k;
      xfer(tv[i].w, tv[i].a, tv[i].sz, tv[i].d, rd, rs, wt);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("vec%0d_resp", i), 32'(rs), 32'(tv[i].resp));
      chk($sformatf("vec%0d_waits", i), 32'(wt), 32'(tv[i].waits));
    end
    cur = 0;
    step(1'b1, mk(1'b1, 32'h400, 3'd2, 32'h1), tk);
    step(1'b0, dp, tk);
    chk("err1_hready", 32'(last_rdy), 32'd0);
    chk("err1_hresp", 32'(last_resp), 32'd1);
    step(1'b1, mk(1'b0, 32'h20, 3'd2, 32'h0), tk);
    chk("err2_hready", 32'(last_rdy), 32'd1);
    chk("err2_hresp", 32'(last_resp), 32'd1);
    step(1'b0, dp, tk);
    chk("err2_accept_rdata", last_rd, 32'h55663344);
    chk("err2_accept_resp", 32'(last_resp), 32'd0);
    cur = 2;
    step(1'b1, mk(1'b1, 32'h30, 3'd2, 32'h12345678), tk);
    step(1'b0, dp, tk);
    chk("midrst_wait", 32'(hready_v[2]), 32'd0);
    hresetn = 1'b0;
    #1;
    chk("midrst_hready", 32'(hready_v[2]), 32'd1);
    chk("midrst_hresp", 32'(hresp_v[2]), 32'd0);
    chk("midrst_hrdata", hrdata_v[2], 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    dp = '{default: 0};
    p  = 0;
    xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, rs, wt);
    chk("midrst_no_write", 32'(rd != 32'h12345678), 32'd1);
    for (int k = 0; k < 3; k++) begin
      int got = 0, guard = 0;
      cur = k;
      while (got < 150 && guard < 4000) begin
        step($urandom_range(0, 3) != 0, rand_xf(), tk);
        got += int'(tk);
        guard++;
      end
      while (dp.v && guard < 4100) begin
        step(1'b0, dp, tk);
        guard++;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-lite memory responder: the slave end of the AHB-lite bus that the testbench driver initiates on. It accepts single and burst beats, stores data in an internal byte-addressed little-endian RAM and returns OKAY or a two-cycle ERROR response. It inserts a programmable number of wait states per transfer. It serves as the DUT-side reference slave, so the driver, monitor and scoreboard can be closed-loop tested.

## Interface
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, width of hwdata/hrdata. Legal values are 32 and 64.
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words. The valid byte range is 0 .. MEM_DEPTH*DATA_WIDTH/8-1.
- WAIT_STATES, 0, number of hready-low cycles inserted in every OKAY data phase (0..15).
- hclk  input  1  bus clock; all logic is on the rising edge.
- hresetn  input  1  asynchronous, active-low reset.
- hsel  input  1  slave select, qualified in the address phase.
- haddr  input  ADDR_WIDTH  byte address.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  input  1  1 = write, 0 = read.
- hsize  input  3  transfer size: 000 byte, 001 half, 010 word, 011 dword.
- hburst  input  3  burst type. Ignored: every beat is an independent transfer.
- hwdata  input  DATA_WIDTH  write data, sampled in the data phase.
- hready  output  1  transfer-done / slave-ready.
- hresp  output  2  00 OKAY, 01 ERROR.
- hrdata  output  DATA_WIDTH  read data.

## Operation
- Address phase is accepted when hsel=1, htrans[1]=1 and hready=1 on a rising edge.
  - On accept, the block registers addr, size and write.
  - IDLE/BUSY beats and unselected beats are not accepted. The next cycle gives a zero-wait OKAY.
- Error check at accept. A beat is an error if any of these holds:
  - the address is outside the valid range;
  - the address is misaligned for hsize;
  - hsize exceeds log2(DATA_WIDTH/8).
- FSM states are IDLE, WAIT, ERR1 and ERR2.
  - IDLE: hready=1, hresp=00. A good accept goes to WAIT when WAIT_STATES>0; otherwise it stays in IDLE with the data phase active next cycle. A bad accept goes to ERR1.
  - WAIT: hready=0, hresp=00. The down-counter loads WAIT_STATES-1 on entry. Exit to IDLE (completion cycle) when it reaches 0.
  - ERR1: hready=0, hresp=01. Always goes to ERR2.
  - ERR2: hready=1, hresp=01. A new address phase may be accepted here, with the same rules as IDLE.
- Write completion happens in the data-phase cycle with hready=1.
  - Lanes: byte offset = addr[log2(DATA_WIDTH/8)-1:0]. 2^size bytes are written from hwdata at those lanes.
  - Other bytes are preserved.
  - Memory updates at the end of that cycle.
- Read completion:
  - In the data-phase cycle with hready=1, hrdata = mem word at addr (combinational from the registered address), with all lanes driven.
  - In every other cycle hrdata=0.
- Pipelining: a new address phase is accepted in the same cycle the previous data phase completes.
- Read-after-write to the same address returns the new data, with no hazard stall.
- Address-phase inputs are ignored while hready=0, because the master is holding them.
- An errored transfer never writes memory. hrdata=0 during ERR1 and ERR2.
- Memory contents are not cleared by reset.

## Timing
- Reset values: hready=1, hresp=00, hrdata=0, state IDLE, counter 0.
  - Reset is asynchronous and takes effect immediately, including mid-WAIT or mid-ERR.
  - The pending transfer is discarded and no write occurs.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles. hready is high only in the last of them.
- Error: exactly two data-phase cycles (ERR1 then ERR2), independent of WAIT_STATES.
- Back-to-back with WAIT_STATES=0: one transfer completes every cycle.
- hresp changes only together with FSM transitions. It is never 01 while in IDLE or WAIT.

## Test plan
- Reset: hold hresetn=0 for 3 cycles with random inputs -> hready=1, hresp=00, hrdata=0 throughout.
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, immediately pipelined with a read of 0x10 -> write completes in cycle 1, read data phase in cycle 2 shows hrdata=0xDEADBEEF, hready=1, hresp=00.
- Byte write: word 0x11223344 at 0x20, then byte write to 0x23 with hwdata=0xAA000000 -> read of 0x20 returns 0xAA223344. A halfword write to 0x22 with hwdata=0x55660000 then makes the read return 0x55663344.
- WAIT_STATES=2: read of 0x10 -> hready=0 for 2 cycles, then hready=1 with hrdata=0xDEADBEEF. Toggling haddr during the wait has no effect.
- Errors: word write to 0x400 (MEM_DEPTH=256), then halfword write to 0x11 -> each gives hready=0/hresp=01 followed by hready=1/hresp=01. Memory is unchanged, and a NONSEQ presented in ERR2 is accepted and completes OKAY.
- Reset mid-op: WAIT_STATES=3, write 0x12345678 to 0x30, assert hresetn=0 in the second wait cycle -> hready=1 immediately, and a read of 0x30 after reset does not return 0x12345678.
